// File: rtl/imem_loader_if.sv
// Byte-stream receive channel and instruction-memory write bus used by imem_loader.
// master: the loader side (consumes bytes, drives memory writes).
// slave: the byte source / memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
) ();

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Program loader: takes a length-prefixed little-endian byte image and writes it word by
// word into instruction memory, holding the core in reset until the load succeeds.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds an XOR trailer byte check.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int unsigned IdxW = ADDR_WIDTH + 1;

  // StLast is the write cycle of the final word when no trailer byte follows; it keeps
  // core_reset high until the last imem_we has been issued.
  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StChk,
    StLast,
    StDone,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q;
  logic [15:0]           len_q;
  logic [1:0]            byte_cnt_q;
  logic [IdxW-1:0]       word_idx_q;
  logic [23:0]           word_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            chk_q;
`endif

  logic        rx_ready;
  logic        accept;
  logic        word_done;
  logic        last_word;
  logic        load_start;
  logic [15:0] len_new;

  assign rx_ready   = (state_q == StLenLo) || (state_q == StLenHi) ||
                      (state_q == StData)  || (state_q == StChk);
  assign accept     = bus.rx_valid && rx_ready;
  assign word_done  = accept && (state_q == StData) && (byte_cnt_q == 2'd3);
  assign last_word  = (32'(word_idx_q) + 32'd1) == 32'(len_q);
  assign load_start = start && ((state_q == StIdle) || (state_q == StDone) ||
                                (state_q == StErr));
  assign len_new    = {bus.rx_data, len_lo_q};

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = rx_ready || (state_q == StLast);
  assign core_reset     = (state_q != StDone);
  assign done           = (state_q == StDone);
  assign error          = (state_q == StErr);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside an active load.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLenLo;
      end
      StLenLo: begin
        if (accept) state_d = StLenHi;
      end
      StLenHi: begin
        if (accept) begin
          if ((len_new == 16'd0) || (32'(len_new) > DEPTH)) state_d = StErr;
          else                                              state_d = StData;
        end
      end
      StData: begin
        if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StLast;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) state_d = (bus.rx_data == chk_q) ? StDone : StErr;
      end
`endif
      StLast: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath: length capture, byte assembly, write strobe generation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      we_q <= word_done;
      if (load_start) begin
        byte_cnt_q <= '0;
        word_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_q      <= '0;
`endif
      end
      if (accept && (state_q == StLenLo)) len_lo_q <= bus.rx_data;
      if (accept && (state_q == StLenHi)) len_q <= len_new;
      if (accept && (state_q == StData)) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_q      <= chk_q ^ bus.rx_data;
`endif
        unique case (byte_cnt_q)
          2'd0: word_q[7:0]   <= bus.rx_data;
          2'd1: word_q[15:8]  <= bus.rx_data;
          2'd2: word_q[23:16] <= bus.rx_data;
          2'd3: begin
            wdata_q    <= {bus.rx_data, word_q};
            addr_q     <= word_idx_q[ADDR_WIDTH-1:0];
            word_idx_q <= word_idx_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
